mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared CPU types for the instruction/data memory arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        RAM_FREE   = 2'd0,
        RAM_BUSY   = 2'd1,
        RAM_ACCESS = 2'd2,
        RAM_ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IACC = 2'd1,
        ARB_DACC = 2'd2,
        ARB_DONE = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter between icache and dcache; MEM_ARB_RR_EN selects round-robin instead of fixed data priority
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    arb_state_t state_q, state_d;
    logic       err_q, err_d;
    logic       d_req, pick_d;

    assign d_req = dREN | dWEN;
    assign err   = err_q & ~RST;

`ifdef MEM_ARB_RR_EN
    gnt_t last_q, last_d;

    // with both sides requesting, serve whichever side was not served last
    always_comb begin
        pick_d = d_req & (~iREN | (last_q == GNT_I));
        last_d = (state_q == ARB_IDLE && (d_req || iREN)) ? (pick_d ? GNT_D : GNT_I) : last_q;
    end

    // last-grant register
    always_ff @(posedge CLK) begin
        if (RST) last_q <= GNT_I;
        else     last_q <= last_d;
    end
`else
    assign pick_d = d_req;
`endif

    // next-state and RAM/requester outputs; reset forces the idle output pattern
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'h0;
        ramstore = 32'h0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = 32'h0;
        dload    = 32'h0;
        case (state_q)
            ARB_IDLE: state_d = pick_d ? ARB_DACC : (iREN ? ARB_IACC : ARB_IDLE);
            ARB_IACC: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                if (!iREN) begin
                    state_d = ARB_IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    iwait   = 1'b0;
                    iload   = ramload;
                    state_d = ARB_DONE;
                end else if (ramstate == RAM_ERROR) begin
                    err_d   = 1'b1;
                    state_d = ARB_DONE;
                end
            end
            ARB_DACC: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = ~dWEN;
                if (!d_req) begin
                    state_d = ARB_IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    dwait   = 1'b0;
                    dload   = ramload;
                    state_d = ARB_DONE;
                end else if (ramstate == RAM_ERROR) begin
                    err_d   = 1'b1;
                    state_d = ARB_DONE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        if (RST) begin
            ramREN   = 1'b0;
            ramWEN   = 1'b0;
            ramaddr  = 32'h0;
            ramstore = 32'h0;
            iwait    = 1'b1;
            dwait    = 1'b1;
            iload    = 32'h0;
            dload    = 32'h0;
        end
    end

    // state and sticky error registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ARB_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus grant-order sequence for mem_arbiter
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST, iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int tests = 0;
    int fails = 0;

    mem_arbiter dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst, iren;
        logic [31:0] ia;
        logic        dren, dwen;
        logic [31:0] da, ds;
        logic [1:0]  rs;
        logic [31:0] rl;
        logic        iw;
        logic [31:0] il;
        logic        dw;
        logic [31:0] dl;
        logic        rr, rw;
        logic [31:0] ra, rst_o;
        logic        er;
    } vec_t;

    vec_t v [31];

    task automatic chk(input string name, input logic [132:0] got, input logic [132:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        v[0]  = '{1,1,'h40,0,0,0,0,0,0,                    1,0,1,0,0,0,0,0,0};
        v[1]  = '{0,1,'h40,0,0,0,0,1,0,                    1,0,1,0,0,0,0,0,0};
        v[2]  = '{0,1,'h40,0,0,0,0,1,0,                    1,0,1,0,1,0,'h40,0,0};
        v[3]  = '{0,1,'h40,0,0,0,0,1,0,                    1,0,1,0,1,0,'h40,0,0};
        v[4]  = '{0,1,'h40,0,0,0,0,2,'h8C010004,           0,'h8C010004,1,0,1,0,'h40,0,0};
        v[5]  = '{0,0,'h40,0,0,0,0,0,0,                    1,0,1,0,0,0,0,0,0};
        v[6]  = '{0,0,0,0,1,'h3000,'hDEADBEEF,0,0,         1,0,1,0,0,0,0,0,0};
        v[7]  = '{0,0,0,0,1,'h3000,'hDEADBEEF,1,0,         1,0,1,0,0,1,'h3000,'hDEADBEEF,0};
        v[8]  = '{0,0,0,0,1,'h3000,'hDEADBEEF,2,'h11,      1,0,0,'h11,0,1,'h3000,'hDEADBEEF,0};
        v[9]  = '{0,0,0,0,0,'h3000,'hDEADBEEF,0,0,         1,0,1,0,0,0,0,0,0};
        v[10] = '{1,0,0,0,0,0,0,0,0,                       1,0,1,0,0,0,0,0,0};
        v[11] = '{0,1,'h80,1,0,'h100,0,0,0,                1,0,1,0,0,0,0,0,0};
        v[12] = '{0,1,'h80,1,0,'h100,0,1,0,                1,0,1,0,1,0,'h100,0,0};
        v[13] = '{0,1,'h80,1,0,'h100,0,2,'h55,             1,0,0,'h55,1,0,'h100,0,0};
        v[14] = '{0,1,'h80,0,0,'h100,0,0,0,                1,0,1,0,0,0,0,0,0};
        v[15] = '{0,1,'h80,0,0,'h100,0,0,0,                1,0,1,0,0,0,0,0,0};
        v[16] = '{0,1,'h80,0,0,'h100,0,2,'h66,             0,'h66,1,0,1,0,'h80,0,0};
        v[17] = '{0,0,'h80,0,0,'h100,0,0,0,                1,0,1,0,0,0,0,0,0};
        v[18] = '{0,0,0,1,0,'h200,0,0,0,                   1,0,1,0,0,0,0,0,0};
        v[19] = '{0,0,0,1,0,'h200,0,3,'h77,                1,0,1,0,1,0,'h200,0,0};
        v[20] = '{0,0,0,0,0,'h200,0,0,0,                   1,0,1,0,0,0,0,0,1};
        v[21] = '{0,0,0,0,0,'h200,0,0,0,                   1,0,1,0,0,0,0,0,1};
        v[22] = '{1,0,0,0,0,0,0,0,0,                       1,0,1,0,0,0,0,0,0};
        v[23] = '{0,1,'h90,0,0,0,0,0,0,                    1,0,1,0,0,0,0,0,0};
        v[24] = '{0,1,'h90,0,0,0,0,1,0,                    1,0,1,0,1,0,'h90,0,0};
        v[25] = '{0,0,'h90,0,0,0,0,1,0,                    1,0,1,0,1,0,'h90,0,0};
        v[26] = '{0,0,'h90,0,0,0,0,0,0,                    1,0,1,0,0,0,0,0,0};
        v[27] = '{0,1,'h90,0,0,0,0,0,0,                    1,0,1,0,0,0,0,0,0};
        v[28] = '{0,1,'h90,0,0,0,0,1,0,                    1,0,1,0,1,0,'h90,0,0};
        v[29] = '{1,1,'h90,0,0,0,0,2,'h99,                 1,0,1,0,0,0,0,0,0};
        v[30] = '{0,0,'h90,0,0,0,0,0,0,                    1,0,1,0,0,0,0,0,0};

        for (int i = 0; i < 31; i++) begin
            @(negedge CLK);
            RST = v[i].rst; iREN = v[i].iren; iaddr = v[i].ia;
            dREN = v[i].dren; dWEN = v[i].dwen; daddr = v[i].da; dstore = v[i].ds;
            ramstate = v[i].rs; ramload = v[i].rl;
            #2;
            chk($sformatf("vec%0d", i),
                {iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err},
                {v[i].iw, v[i].il, v[i].dw, v[i].dl, v[i].rr, v[i].rw, v[i].ra, v[i].rst_o, v[i].er});
        end

        @(negedge CLK);
        RST = 1'b1; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
        iaddr = 32'hA0; daddr = 32'hD0; dstore = 32'h0; ramstate = 2'd0; ramload = 32'h1234;
        @(negedge CLK);
        RST = 1'b0;
        for (int t = 0; t < 4; t++) begin
            logic        found;
            logic [31:0] exp_a;
`ifdef MEM_ARB_RR_EN
            exp_a = (t % 2 == 0) ? 32'hD0 : 32'hA0;
`else
            exp_a = 32'hD0;
`endif
            found = 1'b0;
            for (int c = 0; c < 4 && !found; c++) begin
                if (c > 0 || t > 0) @(negedge CLK);
                ramstate = 2'd0;
                #2;
                if (ramREN) found = 1'b1;
            end
            chk($sformatf("grant%0d_seen", t), {132'h0, found}, {132'h0, 1'b1});
            chk($sformatf("grant%0d_addr", t), {101'h0, ramaddr}, {101'h0, exp_a});
            ramstate = 2'd2;
            #1;
            chk($sformatf("grant%0d_waits", t), {131'h0, iwait, dwait},
                {131'h0, (exp_a == 32'hD0) ? 2'b10 : 2'b01});
        end
        @(negedge CLK);
        ramstate = 2'd0; iREN = 1'b0; dREN = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
